// File: rtl/interp_pkg.sv
// interp_pkg: shared state encoding and factor-to-shift helper for the interpolator.
`default_nettype none
package interp_pkg;

  typedef enum logic {IDLE, EMIT} interp_state_t;

  // log2 of a power-of-two factor; elaboration-time only
  function automatic int interp_shift(input int factor);
    int s;
    s = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < factor) s = i + 1;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interp_lerp.sv
// interp_lerp: y = prev + floor((cur - prev) * k / 2**SHIFT), combinational.
`default_nettype none
module interp_lerp #(
  parameter int W     = 16,
  parameter int SHIFT = 2
) (
  input  logic [W-1:0]     prev,
  input  logic [W-1:0]     cur,
  input  logic [SHIFT-1:0] k,
  output logic [W-1:0]     y
);

  localparam int PW = W + 1 + SHIFT;

  logic signed [W:0]    diff;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] k_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prev_x;

  assign diff   = {cur[W-1], cur} - {prev[W-1], prev};
  assign diff_x = {{SHIFT{diff[W]}}, diff};
  assign k_x    = {{(W+1){1'b0}}, k};
  assign prod   = diff_x * k_x;
  assign prev_x = {{(SHIFT+1){prev[W-1]}}, prev};

  // Result lies between prev and cur, so dropping the top bits is lossless
  assign y = W'(prev_x + (prod >>> SHIFT));

endmodule
`default_nettype wire

// File: rtl/interpolate.sv
// interpolate: 1-to-INTERP_FACTOR linear upsampler with valid/ready on both sides.
// Build option INTERP_ZOH_EN: zero-order hold instead of linear interpolation.
`default_nettype none
module interpolate
  import interp_pkg::*;
#(
  parameter int W             = 16,
  parameter int INTERP_FACTOR = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [W-1:0] x_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [W-1:0] y_data
);

  localparam int SHIFT = interp_shift(INTERP_FACTOR);
  localparam logic [SHIFT-1:0] K_LAST = '1;
  localparam logic [SHIFT-1:0] K_ONE  = SHIFT'(1);

  if (INTERP_FACTOR < 2 || (1 << SHIFT) != INTERP_FACTOR) begin : g_bad_factor
    $error("interpolate: INTERP_FACTOR must be a power of two >= 2");
  end

  interp_state_t    state;
  logic [W-1:0]     prev;
  logic [W-1:0]     cur;
  logic [SHIFT-1:0] k;

  logic last_phase;
  logic y_fire;
  logic x_fire;

  assign last_phase = (k == K_LAST);
  assign y_valid    = (state == EMIT);
  // y_ready feeds x_ready combinationally so a new sample lands with no bubble
  assign x_ready    = (state == IDLE) || ((state == EMIT) && last_phase && y_ready);
  assign y_fire     = y_valid && y_ready;
  assign x_fire     = x_valid && x_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prev  <= '0;
      cur   <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (x_fire) begin
            prev  <= cur;
            cur   <= x_data;
            k     <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (y_fire) begin
            if (!last_phase) begin
              k <= k + K_ONE;
            end else if (x_valid) begin
              prev <= cur;
              cur  <= x_data;
              k    <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTERP_ZOH_EN
  assign y_data = cur;
`else
  interp_lerp #(
    .W     (W),
    .SHIFT (SHIFT)
  ) u_lerp (
    .prev (prev),
    .cur  (cur),
    .k    (k),
    .y    (y_data)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_interpolate.sv
// tb_interpolate: directed self-checking bench for interpolate (W=16, factor 4).
`default_nettype none
module tb_interpolate;

  logic        clk;
  logic        reset;
  logic        x_valid;
  logic        x_ready;
  logic [15:0] x_data;
  logic        y_valid;
  logic        y_ready;
  logic [15:0] y_data;

  int checks;
  int failures;

  interpolate #(
    .W             (16),
    .INTERP_FACTOR (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, then check outputs before the next rising edge
  task automatic step(input string tag, input logic xv, input int xd, input logic yr,
                      input logic eyv, input int ey, input logic exr);
    @(negedge clk);
    x_valid = xv;
    x_data  = xd[15:0];
    y_ready = yr;
    #1;
    chk({tag, ".y_valid"}, int'(y_valid), int'(eyv));
    chk({tag, ".x_ready"}, int'(x_ready), int'(exr));
    if (eyv) chk({tag, ".y_data"}, int'($signed(y_data)), ey);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".y_valid"}, int'(y_valid), 0);
    chk({tag, ".y_data"},  int'($signed(y_data)), 0);
    chk({tag, ".x_ready"}, int'(x_ready), 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    x_valid  = 1'b0;
    x_data   = '0;
    y_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("rst_held");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("rst_release");

`ifndef INTERP_ZOH_EN
    // 0 -> 400, then 400 -> 0 as separate bursts
    step("t1_acc400", 1, 400, 1, 0, 0, 1);
    step("t1_k0", 0, 0, 1, 1, 0,   0);
    step("t1_k1", 0, 0, 1, 1, 100, 0);
    step("t1_k2", 0, 0, 1, 1, 200, 0);
    step("t1_k3", 0, 0, 1, 1, 300, 1);
    step("t1_acc0", 1, 0, 1, 0, 0, 1);
    step("t1b_k0", 0, 0, 1, 1, 400, 0);
    step("t1b_k1", 0, 0, 1, 1, 300, 0);
    step("t1b_k2", 0, 0, 1, 1, 200, 0);
    step("t1b_k3", 0, 0, 1, 1, 100, 1);

    // Back-to-back 400, 0 with x_valid held: 8 valid cycles, no bubble
    step("t2_acc400", 1, 400, 1, 0, 0, 1);
    step("t2_k0", 1, 0, 1, 1, 0,   0);
    step("t2_k1", 1, 0, 1, 1, 100, 0);
    step("t2_k2", 1, 0, 1, 1, 200, 0);
    step("t2_k3", 1, 0, 1, 1, 300, 1);
    step("t2b_k0", 0, 0, 1, 1, 400, 0);
    step("t2b_k1", 0, 0, 1, 1, 300, 0);
    step("t2b_k2", 0, 0, 1, 1, 200, 0);
    step("t2b_k3", 0, 0, 1, 1, 100, 1);

    // 0 -> -5: floor rounding
    step("t3_acc", 1, -5, 1, 0, 0, 1);
    step("t3_k0", 0, 0, 1, 1, 0,  0);
    step("t3_k1", 0, 0, 1, 1, -2, 0);
    step("t3_k2", 0, 0, 1, 1, -3, 0);
    step("t3_k3", 0, 0, 1, 1, -4, 1);

    // -5 -> -32768, then full-scale -32768 -> 32767
    step("t4_acc", 1, -32768, 1, 0, 0, 1);
    step("t4a_k0", 1, 32767, 1, 1, -5,     0);
    step("t4a_k1", 1, 32767, 1, 1, -8196,  0);
    step("t4a_k2", 1, 32767, 1, 1, -16387, 0);
    step("t4a_k3", 1, 32767, 1, 1, -24578, 1);
    step("t4b_k0", 0, 0, 1, 1, -32768, 0);
    step("t4b_k1", 0, 0, 1, 1, -16385, 0);
    step("t4b_k2", 0, 0, 1, 1, -1,     0);
    step("t4b_k3", 0, 0, 1, 1, 16383,  1);

    // Backpressure at k=1 of 0 -> 400; x_valid during stall must be ignored
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("t5_rst");
    @(negedge clk);
    reset = 1'b0;
    step("t5_acc", 1, 400, 1, 0, 0, 1);
    step("t5_k0",  0, 0,   1, 1, 0,   0);
    step("t5_hold0", 1, 777, 0, 1, 100, 0);
    step("t5_hold1", 1, 777, 0, 1, 100, 0);
    step("t5_hold2", 1, 777, 0, 1, 100, 0);
    step("t5_k1",  0, 0, 1, 1, 100, 0);
    step("t5_k2",  0, 0, 1, 1, 200, 0);
    step("t5_k3",  0, 0, 1, 1, 300, 1);

    // 400 -> 800, reset at k=2 aborts the burst
    step("t6_acc", 1, 800, 1, 0, 0, 1);
    step("t6_k0",  0, 0, 1, 1, 400, 0);
    step("t6_k1",  0, 0, 1, 1, 500, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("t6_rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("t6_after");
    step("t6_idle0", 0, 0, 1, 0, 0, 1);
    step("t6_idle1", 0, 0, 1, 0, 0, 1);
    chk("t6_idle_y", int'($signed(y_data)), 0);
`else
    // Zero-order hold: every phase equals the newest input
    step("z_acc400", 1, 400, 1, 0, 0, 1);
    step("z_k0", 0, 0, 1, 1, 400, 0);
    step("z_k1", 0, 0, 1, 1, 400, 0);
    step("z_k2", 0, 0, 1, 1, 400, 0);
    step("z_k3", 1, -7, 1, 1, 400, 1);
    step("zb_k0", 0, 0, 1, 1, -7, 0);
    step("zb_hold", 0, 0, 0, 1, -7, 0);
    step("zb_k1", 0, 0, 1, 1, -7, 0);
    step("zb_k2", 0, 0, 1, 1, -7, 0);
    step("zb_k3", 0, 0, 1, 1, -7, 1);
    step("z_idle", 0, 0, 1, 0, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
